// File: rtl/membus_arbiter_if.sv
// CPU-side request/grant bundle between the two requesters and membus_arbiter.
// The arbiter takes the slave view; the requesters (or a bench) take the master view.
interface membus_arbiter_if;
   logic        req0;
   logic        req1;
   logic        rw0;
   logic        rw1;
   logic [15:0] addr0;
   logic [15:0] addr1;
   logic [63:0] wdata0;
   logic [63:0] wdata1;
   logic        gnt0;
   logic        gnt1;
   logic        done0;
   logic        done1;
   logic [63:0] rdata;
   logic        busy;

   modport slave (
      input  req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1,
      output gnt0, gnt1, done0, done1, rdata, busy
   );

   modport master (
      output req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1,
      input  gnt0, gnt1, done0, done1, rdata, busy
   );
endinterface

// File: rtl/membus_arbiter.sv
// Round-robin two-port arbiter and 4-word burst sequencer for the multiplexed
// AddrData memory bus; returns packed read bursts to the winning requester.
module membus_arbiter #(
   parameter int BURST_LEN = 4,
   parameter int READ_LAT  = 1
) (
   input  logic                   clk,
   input  logic                   resetH,
   membus_arbiter_if.slave        cpu,
   inout  wire  [15:0]            AddrData,
   output logic                   AddrValid,
   output logic                   rw
);
   // state  | meaning
   // IDLE   | waiting for a request; doubles as bus turnaround cycle
   // ADDR   | address phase: AddrValid high, address on AddrData
   // WRITE  | driving write beats 0..3
   // RDWAIT | read latency padding beyond the first cycle, bus released
   // READ   | capturing read beats 0..3 from AddrData
   // DONE   | completion pulse to the winner, pointer update
   typedef enum logic [2:0] {IDLE, ADDR, WRITE, RDWAIT, READ, DONE} state_t;

   localparam logic [1:0] LAST_BEAT = 2'(BURST_LEN - 1);
   localparam logic [7:0] WAIT_LOAD = 8'((READ_LAT > 1) ? (READ_LAT - 2) : 0);

   state_t      state;
   logic        ptr;
   logic        winner;
   logic        grant1;
   logic [63:0] wdata_q;
   logic [47:0] shadow;
   logic [1:0]  beat;
   logic [7:0]  wait_cnt;
   logic        drive_en;
   logic [15:0] drive_val;

   assign AddrData = drive_en ? drive_val : 16'hzzzz;

   // ptr holds the last-served port; on contention the other port wins
   always_comb begin
      grant1 = 1'b0;
      grant1 = cpu.req1 && (!cpu.req0 || !ptr);
   end

   function automatic logic [15:0] word_at(input logic [63:0] d, input logic [1:0] k);
      logic [15:0] w;
      case (k)
         2'd0:    w = d[15:0];
         2'd1:    w = d[31:16];
         2'd2:    w = d[47:32];
         default: w = d[63:48];
      endcase
      return w;
   endfunction

   always_ff @(posedge clk or posedge resetH) begin
      if (resetH) begin
         state     <= IDLE;
         ptr       <= 1'b1;
         winner    <= 1'b0;
         wdata_q   <= '0;
         shadow    <= '0;
         beat      <= '0;
         wait_cnt  <= '0;
         drive_en  <= 1'b0;
         drive_val <= '0;
         AddrValid <= 1'b0;
         rw        <= 1'b1;
         cpu.gnt0  <= 1'b0;
         cpu.gnt1  <= 1'b0;
         cpu.done0 <= 1'b0;
         cpu.done1 <= 1'b0;
         cpu.rdata <= '0;
         cpu.busy  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cpu.req0 || cpu.req1) begin
                  winner    <= grant1;
                  rw        <= grant1 ? cpu.rw1 : cpu.rw0;
                  drive_val <= grant1 ? cpu.addr1 : cpu.addr0;
                  wdata_q   <= grant1 ? cpu.wdata1 : cpu.wdata0;
                  drive_en  <= 1'b1;
                  AddrValid <= 1'b1;
                  cpu.gnt0  <= !grant1;
                  cpu.gnt1  <= grant1;
                  cpu.busy  <= 1'b1;
                  state     <= ADDR;
               end
            end
            ADDR: begin
               AddrValid <= 1'b0;
               if (!rw) begin
                  drive_val <= word_at(wdata_q, 2'd0);
                  state     <= WRITE;
               end else begin
                  drive_en <= 1'b0;
                  wait_cnt <= WAIT_LOAD;
                  state    <= (READ_LAT == 1) ? READ : RDWAIT;
               end
            end
            WRITE: begin
               beat <= beat + 2'd1;
               if (beat == LAST_BEAT) begin
                  drive_en  <= 1'b0;
                  cpu.done0 <= !winner;
                  cpu.done1 <= winner;
                  state     <= DONE;
               end else begin
                  drive_val <= word_at(wdata_q, beat + 2'd1);
               end
            end
            RDWAIT: begin
               if (wait_cnt == 8'd0) begin
                  state <= READ;
               end else begin
                  wait_cnt <= wait_cnt - 8'd1;
               end
            end
            READ: begin
               beat <= beat + 2'd1;
               case (beat)
                  2'd0:    shadow[15:0]  <= AddrData;
                  2'd1:    shadow[31:16] <= AddrData;
                  2'd2:    shadow[47:32] <= AddrData;
                  default: shadow        <= shadow;
               endcase
               // the final beat goes straight into rdata alongside the shadow words
               if (beat == LAST_BEAT) begin
                  cpu.rdata <= {AddrData, shadow};
                  cpu.done0 <= !winner;
                  cpu.done1 <= winner;
                  state     <= DONE;
               end
            end
            DONE: begin
               cpu.done0 <= 1'b0;
               cpu.done1 <= 1'b0;
               cpu.gnt0  <= 1'b0;
               cpu.gnt1  <= 1'b0;
               cpu.busy  <= 1'b0;
               ptr       <= winner;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_membus_arbiter.sv
// Scoreboard bench for membus_arbiter: two instances (read latency 1 and 3),
// expected address phases and completions queued by stimulus, popped by monitors.
module tb_membus_arbiter;
   typedef struct {
      int          port;
      bit          rd;
      logic [15:0] addr;
      logic [63:0] data;
      int          addr_cyc;
   } txn_t;

   logic        clk;
   logic        resetH;
   logic        probe_en;
   wire  [15:0] bus1;
   wire  [15:0] bus3;
   wire         av1;
   wire         av3;
   wire         rwb1;
   wire         rwb3;

   int          cyc;
   int          checks;
   int          errors;
   bit          flush [2];
   logic [15:0] mem_base [2];
   txn_t        addr_q [2][$];
   txn_t        done_q [2][$];

   membus_arbiter_if cpu1 ();
   membus_arbiter_if cpu3 ();

   membus_arbiter #(.BURST_LEN(4), .READ_LAT(1)) dut1 (
      .clk(clk), .resetH(resetH), .cpu(cpu1),
      .AddrData(bus1), .AddrValid(av1), .rw(rwb1)
   );

   membus_arbiter #(.BURST_LEN(4), .READ_LAT(3)) dut3 (
      .clk(clk), .resetH(resetH), .cpu(cpu3),
      .AddrData(bus3), .AddrValid(av3), .rw(rwb3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : gen_mon
      localparam int LAT = (g == 0) ? 1 : 3;
      wire [15:0] ad  = (g == 0) ? bus1 : bus3;
      wire        av  = (g == 0) ? av1 : av3;
      wire        rws = (g == 0) ? rwb1 : rwb3;
      wire        gn0 = (g == 0) ? cpu1.gnt0 : cpu3.gnt0;
      wire        gn1 = (g == 0) ? cpu1.gnt1 : cpu3.gnt1;
      wire        dn0 = (g == 0) ? cpu1.done0 : cpu3.done0;
      wire        dn1 = (g == 0) ? cpu1.done1 : cpu3.done1;
      wire        bsy = (g == 0) ? cpu1.busy : cpu3.busy;
      wire [63:0] rdt = (g == 0) ? cpu1.rdata : cpu3.rdata;
      logic        mem_en;
      logic [15:0] mem_val;

      if (g == 0) begin : g_bus1
         assign bus1 = mem_en ? mem_val : (probe_en ? 16'hBEEF : 16'hzzzz);
      end else begin : g_bus3
         assign bus3 = mem_en ? mem_val : 16'hzzzz;
      end

      // memory model: words base+k in cycles addr+LAT .. addr+LAT+3
      initial begin : mem_model
         int rd_start;
         rd_start = -100;
         mem_en   = 1'b0;
         mem_val  = '0;
         forever begin
            @(posedge clk);
            #1;
            if (av && rws) rd_start = cyc + LAT;
            if (cyc >= rd_start && cyc < rd_start + 4) begin
               mem_en  = 1'b1;
               mem_val = mem_base[g] + 16'(cyc - rd_start);
            end else begin
               mem_en = 1'b0;
            end
         end
      end

      initial begin : monitor
         txn_t        t;
         bit          wactive;
         int          wbeat;
         logic [63:0] wd;
         bit          idle_chk;
         wactive  = 0;
         wbeat    = 0;
         wd       = '0;
         idle_chk = 0;
         forever begin
            @(negedge clk);
            if (flush[g]) begin
               wactive  = 0;
               idle_chk = 0;
            end else begin
               check("gnt_exclusive", {63'd0, gn0 && gn1}, 64'd0);
               check("busy_vs_gnt", {63'd0, gn0 || gn1}, {63'd0, bsy});
               if (mem_en) check("bus_released", {48'd0, ad}, {48'd0, mem_val});
               if (idle_chk) begin
                  check("idle_after_done", {61'd0, bsy, dn1, dn0}, 64'd0);
                  idle_chk = 0;
               end
               if (wactive) begin
                  check("write_beat", {48'd0, ad}, {48'd0, wd[16*wbeat +: 16]});
                  wbeat++;
                  if (wbeat == 4) wactive = 0;
               end
               if (av) begin
                  check("addr_expected", {63'd0, addr_q[g].size() != 0}, 64'd1);
                  if (addr_q[g].size() != 0) begin
                     t = addr_q[g].pop_front();
                     check("addr_cycle", 64'(cyc), 64'(t.addr_cyc));
                     check("addr_value", {48'd0, ad}, {48'd0, t.addr});
                     check("addr_rw", {63'd0, rws}, {63'd0, t.rd});
                     check("addr_gnt", {62'd0, gn1, gn0}, (t.port == 0) ? 64'd1 : 64'd2);
                     if (!t.rd) begin
                        wactive = 1;
                        wbeat   = 0;
                        wd      = t.data;
                     end
                  end
               end
               if (dn0 || dn1) begin
                  check("done_expected", {63'd0, done_q[g].size() != 0}, 64'd1);
                  if (done_q[g].size() != 0) begin
                     t = done_q[g].pop_front();
                     check("done_port", {62'd0, dn1, dn0}, (t.port == 0) ? 64'd1 : 64'd2);
                     check("done_cycle", 64'(cyc), 64'(t.addr_cyc + (t.rd ? 4 + LAT : 5)));
                     check("done_gnt_held", {63'd0, (t.port == 0) ? gn0 : gn1}, 64'd1);
                     if (t.rd) check("rdata", rdt, t.data);
                  end
                  idle_chk = 1;
               end
            end
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic drive_req(input int g, input int port, input logic v, input logic rd,
                            input logic [15:0] a, input logic [63:0] d);
      if (g == 0) begin
         if (port == 0) begin
            cpu1.req0 = v; cpu1.rw0 = rd; cpu1.addr0 = a; cpu1.wdata0 = d;
         end else begin
            cpu1.req1 = v; cpu1.rw1 = rd; cpu1.addr1 = a; cpu1.wdata1 = d;
         end
      end else begin
         if (port == 0) begin
            cpu3.req0 = v; cpu3.rw0 = rd; cpu3.addr0 = a; cpu3.wdata0 = d;
         end else begin
            cpu3.req1 = v; cpu3.rw1 = rd; cpu3.addr1 = a; cpu3.wdata1 = d;
         end
      end
   endtask

   task automatic expect_txn(input int g, input int port, input bit rd, input logic [15:0] a,
                             input logic [63:0] d, input int acyc);
      txn_t t;
      t.port = port; t.rd = rd; t.addr = a; t.data = d; t.addr_cyc = acyc;
      addr_q[g].push_back(t);
      done_q[g].push_back(t);
   endtask

   // request held for exactly one IDLE cycle; d is wdata for writes, expected rdata for reads
   task automatic issue(input int g, input int port, input bit rd, input logic [15:0] a,
                        input logic [63:0] d);
      drive_req(g, port, 1'b1, rd, a, rd ? 64'd0 : d);
      expect_txn(g, port, rd, a, d, cyc + 1);
      wait_cyc(1);
      drive_req(g, port, 1'b0, rd, a, rd ? 64'd0 : d);
   endtask

   task automatic drain(input int g);
      for (int i = 0; i < 40; i++) begin
         if (addr_q[g].size() == 0 && done_q[g].size() == 0) break;
         wait_cyc(1);
      end
      check("drain", 64'(addr_q[g].size() + done_q[g].size()), 64'd0);
      wait_cyc(2);
   endtask

   initial begin
      int m;
      checks   = 0;
      errors   = 0;
      probe_en = 1'b0;
      flush[0] = 1'b1;
      flush[1] = 1'b1;
      mem_base[0] = 16'h00A0;
      mem_base[1] = 16'h00C0;
      for (int g = 0; g < 2; g++)
         for (int p = 0; p < 2; p++) drive_req(g, p, 1'b0, 1'b0, 16'h0, 64'h0);
      resetH = 1'b1;
      #1;
      check("reset_rw", {62'd0, rwb3, rwb1}, 64'd3);
      check("reset_rdata", cpu1.rdata, 64'd0);
      wait_cyc(3);
      resetH   = 1'b0;
      flush[0] = 1'b0;
      flush[1] = 1'b0;
      wait_cyc(1);

      issue(1, 0, 1'b1, 16'h1000, 64'h00C3_00C2_00C1_00C0);
      drain(1);

      issue(0, 1, 1'b1, 16'h2010, 64'h00A3_00A2_00A1_00A0);
      drain(0);

      issue(0, 0, 1'b0, 16'h1004, 64'h4444_3333_2222_1111);
      drain(0);

      // abandon a write during beat 1; port 0 was served last so pointer must reset
      issue(0, 0, 1'b0, 16'h3000, 64'h8888_7777_6666_5555);
      wait_cyc(2);
      flush[0] = 1'b1;
      flush[1] = 1'b1;
      addr_q[0].delete();
      done_q[0].delete();
      resetH = 1'b1;
      drive_req(0, 0, 1'b1, 1'b0, 16'h4000, 64'h0D0D_0C0C_0B0B_0A0A);
      drive_req(0, 1, 1'b1, 1'b0, 16'h5000, 64'h1D1D_1C1C_1B1B_1A1A);
      #1;
      probe_en = 1'b1;
      #1;
      check("rst_bus_released", {48'd0, bus1}, 64'h0000_0000_0000_BEEF);
      check("rst_gnt", {62'd0, cpu1.gnt1, cpu1.gnt0}, 64'd0);
      check("rst_done", {62'd0, cpu1.done1, cpu1.done0}, 64'd0);
      check("rst_busy_av", {62'd0, cpu1.busy, av1}, 64'd0);
      check("rst_rw", {63'd0, rwb1}, 64'd1);
      check("rst_rdata", cpu1.rdata, 64'd0);
      wait_cyc(2);
      resetH   = 1'b0;
      probe_en = 1'b0;
      flush[0] = 1'b0;
      flush[1] = 1'b0;
      m = cyc;
      expect_txn(0, 0, 1'b0, 16'h4000, 64'h0D0D_0C0C_0B0B_0A0A, m + 1);
      expect_txn(0, 1, 1'b0, 16'h5000, 64'h1D1D_1C1C_1B1B_1A1A, m + 8);
      expect_txn(0, 0, 1'b0, 16'h4000, 64'h0D0D_0C0C_0B0B_0A0A, m + 15);
      wait_cyc(15);
      drive_req(0, 0, 1'b0, 1'b0, 16'h0, 64'h0);
      drive_req(0, 1, 1'b0, 1'b0, 16'h0, 64'h0);
      drain(0);

      mem_base[0] = 16'h0050;
      issue(0, 0, 1'b1, 16'h6020, 64'h0053_0052_0051_0050);
      drain(0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
